// File: rtl/shift_reg_pkg.sv
// Shared encodings for the parametrised shift register: manual modes, FSM states,
// transfer direction and the per-cell next-value select.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Right neighbour is the next-lower bit (feeds left moves), left neighbour the next-higher bit.
    typedef enum logic [2:0] {
        CELL_HOLD       = 3'd0,
        CELL_LOAD       = 3'd1,
        CELL_FROM_RIGHT = 3'd2,
        CELL_FROM_LEFT  = 3'd3,
        CELL_ZERO       = 3'd4
    } cell_sel_e;

endpackage

// File: rtl/shift_reg_cell.sv
// One register bit with a hold/load/neighbour/zero next-value mux and
// asynchronous active-low reset to its own reset value.
module shift_reg_cell
    import shift_reg_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    input  cell_sel_e sel,
    input  logic      load_bit,
    input  logic      right_bit,
    input  logic      left_bit,
    output logic      q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_BIT;
        end else begin
            case (sel)
                CELL_LOAD:       q <= load_bit;
                CELL_FROM_RIGHT: q <= right_bit;
                CELL_FROM_LEFT:  q <= left_bit;
                CELL_ZERO:       q <= 1'b0;
                default:         q <= q;
            endcase
        end
    end

endmodule

// File: rtl/param_shift_register.sv
// Universal WIDTH-bit shift register with manual modes and an automatic
// serial-transfer engine (PISO/SIPO) with busy/done handshakes.
module param_shift_register
    import shift_reg_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
    localparam int                CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    cnt
);

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e          state, state_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            dir_lat, dir_nxt;
    cell_sel_e       cell_sel;
    logic            fill_r, fill_l;
    logic [WIDTH:0]  from_right;
    logic [WIDTH:0]  from_left;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dir_lat <= DIR_LEFT;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dir_lat <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_lat;
        cell_sel  = CELL_HOLD;
        fill_r    = ser_in_r;
        fill_l    = ser_in_l;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // start wins over mode; q is left untouched on the accepting edge
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = '0;
                    dir_nxt   = dir;
                end else begin
                    case (mode)
                        MODE_LOAD: cell_sel = CELL_LOAD;
                        MODE_SHL:  cell_sel = CELL_FROM_RIGHT;
                        MODE_SHR:  cell_sel = CELL_FROM_LEFT;
                        MODE_ROL: begin
                            cell_sel = CELL_FROM_RIGHT;
                            fill_r   = q[WIDTH-1];
                        end
                        MODE_ROR: begin
                            cell_sel = CELL_FROM_LEFT;
                            fill_l   = q[0];
                        end
                        MODE_CLR:  cell_sel = CELL_ZERO;
                        default:   cell_sel = CELL_HOLD;
                    endcase
                end
            end
            ST_SHIFT: begin
                cell_sel = (dir_lat == DIR_RIGHT) ? CELL_FROM_LEFT : CELL_FROM_RIGHT;
                cnt_nxt  = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Padded neighbour vectors put the serial/rotate fill bits at the open ends.
    assign from_right = {q, fill_r};
    assign from_left  = {fill_l, q};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shift_reg_cell #(
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .sel       (cell_sel),
            .load_bit  (load_data[i]),
            .right_bit (from_right[i]),
            .left_bit  (from_left[i+1]),
            .q         (q[i])
        );
    end

    assign ser_out = (dir_lat == DIR_RIGHT) ? q[0] : q[WIDTH-1];
    assign busy    = (state == ST_SHIFT);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_param_shift_register.sv
// Randomised self-checking bench for param_shift_register (WIDTH=8 and WIDTH=2 instances).
module tb_param_shift_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ser_in_l, ser_in_r, start, dir;
    logic [2:0] mode;
    logic [7:0] load_data, q;
    logic       ser_out, busy, done;
    logic [3:0] cnt;

    logic       rst2, sl2, sr2, start2, dir2;
    logic [2:0] mode2;
    logic [1:0] load2, q2;
    logic       so2, busy2, done2;
    logic [1:0] cnt2;

    int tests = 0;
    int fails = 0;
    logic [7:0] mq;

    param_shift_register #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .mode(mode), .load_data(load_data),
        .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .start(start), .dir(dir),
        .q(q), .ser_out(ser_out), .busy(busy), .done(done), .cnt(cnt)
    );

    param_shift_register #(.WIDTH(2), .RESET_VAL(2'b10)) dut2 (
        .clk(clk), .rst(rst2), .mode(mode2), .load_data(load2),
        .ser_in_l(sl2), .ser_in_r(sr2), .start(start2), .dir(dir2),
        .q(q2), .ser_out(so2), .busy(busy2), .done(done2), .cnt(cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference for the manual modes, written as plain word arithmetic.
    function automatic logic [7:0] ref_mode(input logic [7:0] cur, input logic [2:0] m,
                                            input logic [7:0] ld, input logic sl, input logic sr);
        case (m)
            3'd1: return ld;
            3'd2: return (cur << 1) | 8'(sr);
            3'd3: return (cur >> 1) | (8'(sl) << 7);
            3'd4: return (cur << 1) | (cur >> 7);
            3'd5: return (cur >> 1) | (cur << 7);
            3'd6: return 8'h00;
            default: return cur;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b0; rst2 = 1'b0;
        step();
        tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q: got %h want 00", q); end
        tests++; if (q2 !== 2'b10) begin fails++; $display("FAIL reset_q2: got %b want 10", q2); end
        rst = 1'b1; rst2 = 1'b1;
        mode = 3'd1; load_data = 8'hFF;
        step();
        tests++; if (q !== 8'hFF) begin fails++; $display("FAIL reset_preload: got %h want ff", q); end
        mode = 3'd0;
        #3 rst = 1'b0;
        #1;
        tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_async_q: got %h want 00", q); end
        tests++; if ({busy, done, cnt} !== 6'd0) begin fails++; $display("FAIL reset_async_ctl: got busy=%b done=%b cnt=%0d want 0", busy, done, cnt); end
        #1 rst = 1'b1;
        step(); step();
        tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_hold: got %h want 00", q); end
        mq = 8'h00;
    endtask

    task automatic test_modes();
        logic [2:0] tm [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [7:0] te [6] = '{8'h4B, 8'h52, 8'h4B, 8'hD2, 8'h00, 8'hA5};
        for (int i = 0; i < 6; i++) begin
            mode = 3'd1; load_data = 8'hA5; step();
            mode = tm[i]; ser_in_r = 1'b1; ser_in_l = 1'b0; load_data = 8'h00; step();
            tests++; if (q !== te[i]) begin fails++; $display("FAIL mode_%0d: got %h want %h", tm[i], q, te[i]); end
        end
        mq = 8'hA5;
        for (int i = 0; i < 60; i++) begin
            mode = 3'($urandom_range(0, 7));
            load_data = 8'($urandom);
            ser_in_l = 1'($urandom); ser_in_r = 1'($urandom);
            step();
            mq = ref_mode(mq, mode, load_data, ser_in_l, ser_in_r);
            tests++; if (q !== mq) begin fails++; $display("FAIL mode_rand_%0d: mode=%0d got %h want %h", i, mode, q, mq); end
        end
        mode = 3'd0;
    endtask

    task automatic test_transfer(input logic d, input logic [7:0] init, input logic [7:0] rx);
        logic b;
        mode = 3'd1; load_data = init; step();
        mode = 3'($urandom_range(1, 6)); dir = d; start = 1'b1; step();
        start = 1'b0; dir = ~d;
        tests++; if (q !== init || busy !== 1'b1 || cnt !== 4'd0) begin fails++; $display("FAIL xfer_accept: q=%h busy=%b cnt=%0d want q=%h busy=1 cnt=0", q, busy, cnt, init); end
        mq = init;
        for (int k = 1; k <= 8; k++) begin
            tests++; if (ser_out !== (d ? mq[0] : mq[7])) begin fails++; $display("FAIL xfer_ser_out_%0d: got %b want %b", k, ser_out, d ? mq[0] : mq[7]); end
            b = d ? rx[k-1] : rx[8-k];
            ser_in_l = d ? b : 1'($urandom);
            ser_in_r = d ? 1'($urandom) : b;
            mode = 3'($urandom_range(0, 7));
            step();
            mq = d ? {b, mq[7:1]} : {mq[6:0], b};
            tests++; if (q !== mq || cnt !== 4'(k)) begin fails++; $display("FAIL xfer_step_%0d: q=%h cnt=%0d want q=%h cnt=%0d", k, q, cnt, mq, k); end
            tests++; if (busy !== (k < 8) || done !== (k == 8)) begin fails++; $display("FAIL xfer_hs_%0d: busy=%b done=%b want %b %b", k, busy, done, k < 8, k == 8); end
        end
        tests++; if (q !== rx) begin fails++; $display("FAIL xfer_final: got %h want %h", q, rx); end
        step();
        tests++; if (done !== 1'b0 || busy !== 1'b0 || cnt !== 4'd0 || q !== rx) begin fails++; $display("FAIL xfer_idle: done=%b busy=%b cnt=%0d q=%h want 0 0 0 %h", done, busy, cnt, q, rx); end
        tests++; if (ser_out !== (d ? rx[0] : rx[7])) begin fails++; $display("FAIL xfer_idle_ser_out: got %b want %b", ser_out, d ? rx[0] : rx[7]); end
        mode = 3'd0; dir = 1'b0;
    endtask

    task automatic test_interference();
        mode = 3'd1; load_data = 8'hA5; step();
        mode = 3'd0; dir = 1'b0; start = 1'b1; step();
        start = 1'b0; ser_in_r = 1'b1;
        step(); step(); step();
        tests++; if (cnt !== 4'd3) begin fails++; $display("FAIL intf_cnt3: got %0d want 3", cnt); end
        start = 1'b1; mode = 3'd6; step();
        tests++; if (cnt !== 4'd4 || busy !== 1'b1 || q !== 8'h5F) begin fails++; $display("FAIL intf_ignore: cnt=%0d busy=%b q=%h want 4 1 5f", cnt, busy, q); end
        start = 1'b0; mode = 3'd0; step();
        tests++; if (cnt !== 4'd5 || q !== 8'hBF) begin fails++; $display("FAIL intf_cnt5: cnt=%0d q=%h want 5 bf", cnt, q); end
        #3 rst = 1'b0;
        #1;
        tests++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || cnt !== 4'd0) begin fails++; $display("FAIL intf_reset: q=%h busy=%b done=%b cnt=%0d want 00 0 0 0", q, busy, done, cnt); end
        #1 rst = 1'b1;
        step();
        tests++; if (busy !== 1'b0 || q !== 8'h00) begin fails++; $display("FAIL intf_idle: busy=%b q=%h want 0 00", busy, q); end
        test_transfer(1'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_boundary();
        rst2 = 1'b0;
        #1;
        tests++; if (q2 !== 2'b10 || busy2 !== 1'b0 || cnt2 !== 2'd0) begin fails++; $display("FAIL w2_reset: q=%b busy=%b cnt=%0d want 10 0 0", q2, busy2, cnt2); end
        #1 rst2 = 1'b1;
        step();
        dir2 = 1'b0; mode2 = 3'd0; start2 = 1'b1; step();
        start2 = 1'b0;
        tests++; if (busy2 !== 1'b1 || cnt2 !== 2'd0 || so2 !== 1'b1) begin fails++; $display("FAIL w2_accept: busy=%b cnt=%0d ser_out=%b want 1 0 1", busy2, cnt2, so2); end
        sr2 = 1'b0; step();
        tests++; if (busy2 !== 1'b1 || cnt2 !== 2'd1 || so2 !== 1'b0) begin fails++; $display("FAIL w2_e1: busy=%b cnt=%0d ser_out=%b want 1 1 0", busy2, cnt2, so2); end
        sr2 = 1'b1; step();
        tests++; if (busy2 !== 1'b0 || done2 !== 1'b1 || cnt2 !== 2'd2 || q2 !== 2'b01) begin fails++; $display("FAIL w2_e2: busy=%b done=%b cnt=%0d q=%b want 0 1 2 01", busy2, done2, cnt2, q2); end
        start2 = 1'b1; step();
        tests++; if (busy2 !== 1'b0 || done2 !== 1'b0 || cnt2 !== 2'd0) begin fails++; $display("FAIL w2_done_start: busy=%b done=%b cnt=%0d want 0 0 0", busy2, done2, cnt2); end
        step();
        start2 = 1'b0;
        tests++; if (busy2 !== 1'b1 || cnt2 !== 2'd0 || q2 !== 2'b01) begin fails++; $display("FAIL w2_restart: busy=%b cnt=%0d q=%b want 1 0 01", busy2, cnt2, q2); end
        step(); step();
        tests++; if (done2 !== 1'b1 || cnt2 !== 2'd2 || q2 !== 2'b11) begin fails++; $display("FAIL w2_second: done=%b cnt=%0d q=%b want 1 2 11", done2, cnt2, q2); end
        step();
        tests++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin fails++; $display("FAIL w2_end: done=%b busy=%b want 0 0", done2, busy2); end
    endtask

    initial begin
        rst = 1'b0; mode = 3'd0; load_data = 8'h00; ser_in_l = 1'b0; ser_in_r = 1'b0;
        start = 1'b0; dir = 1'b0;
        rst2 = 1'b0; mode2 = 3'd0; load2 = 2'b00; sl2 = 1'b0; sr2 = 1'b0;
        start2 = 1'b0; dir2 = 1'b0;
        #1;
        test_reset();
        test_modes();
        test_transfer(1'b0, 8'hA5, 8'h3C);
        test_transfer(1'b1, 8'hA5, 8'h0F);
        test_interference();
        for (int i = 0; i < 4; i++) begin
            test_transfer(1'($urandom), 8'($urandom), 8'($urandom));
        end
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
